// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART types and constants: frame geometry and the transmit/receive
// FSM state encodings used by the buffered transmitter and the duplex wrapper.
package uart_tx_buffered_pkg;

   localparam int UART_FRAME_BITS = 11;
   localparam int UART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data_byte);
      return ^data_byte;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Bus-side handshake between the peripheral register block and the
// buffered transmitter: byte push strobe plus FIFO and frame status.
interface uart_tx_buffered_if;
   logic [7:0] tx_data;
   logic       tx_send;
   logic       fifo_full;
   logic       fifo_empty;
   logic       tx_done;
   logic       overflow;

   modport master (
      output tx_data,
      output tx_send,
      input  fifo_full,
      input  fifo_empty,
      input  tx_done,
      input  overflow
   );

   modport slave (
      input  tx_data,
      input  tx_send,
      output fifo_full,
      output fifo_empty,
      output tx_done,
      output overflow
   );
endinterface

// File: rtl/uart_tx_buffered_fifo.sv
// Small synchronous FIFO holding bytes queued for transmission. Pointers
// carry one extra wrap bit so full and empty differ only in that MSB.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // A push into a full FIFO still lands when the head leaves in the same cycle.
   always_comb begin
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);
   end

   // Occupancy flags come straight from the pointers, so they track the latest edge.
   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      rd_data = mem[rd_ptr[AW-1:0]];
   end

   // Pointer advance; reset drops every queued byte.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes queued through a small FIFO are sent as
// start, 8 data bits LSB first, even-XOR parity and one stop bit, with
// consecutive frames chained without an idle bit.
module uart_tx_buffered
   import uart_tx_buffered_pkg::*;
#(
   parameter int BIT_COUNTS = 5200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               n_rst,
   uart_tx_buffered_if.slave  bus,
   output logic               tx,
   output logic [2:0]         tx_state
);

   localparam int CW = (BIT_COUNTS > 2) ? $clog2(BIT_COUNTS) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_COUNTS - 1);

   tx_state_t  state;
   tx_state_t  state_next;
   logic [CW-1:0] baud_cnt;
   logic [CW-1:0] baud_next;
   logic [2:0] bit_idx;
   logic [2:0] bit_idx_next;
   logic [7:0] shift_reg;
   logic [7:0] shift_next;
   logic       parity_bit;
   logic       parity_next;
   logic       tx_reg;
   logic       tx_next;
   logic       overflow_reg;
   logic       baud_wrap;
   logic       fifo_pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_head;

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .push    (bus.tx_send),
      .pop     (fifo_pop),
      .wr_data (bus.tx_data),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // State register for the frame sequencer.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= TX_IDLE;
      else        state <= state_next;
   end

   // Next-state: every bit lasts one full baud period; STOP chains straight into START.
   always_comb begin
      baud_wrap  = (baud_cnt == BAUD_LAST);
      state_next = state;
      case (state)
         TX_IDLE:   if (!fifo_empty) state_next = TX_START;
         TX_START:  if (baud_wrap) state_next = TX_DATA;
         TX_DATA:   if (baud_wrap && bit_idx == 3'd7) state_next = TX_PARITY;
         TX_PARITY: if (baud_wrap) state_next = TX_STOP;
         TX_STOP:   if (baud_wrap) state_next = fifo_empty ? TX_IDLE : TX_START;
         default:   state_next = TX_IDLE;
      endcase
   end

   // Outputs and datapath next values: pop/load on frame start, shift on DATA bit edges.
   always_comb begin
      fifo_pop = !fifo_empty &&
                 ((state == TX_IDLE) || (state == TX_STOP && baud_wrap));

      shift_next  = shift_reg;
      parity_next = parity_bit;
      if (fifo_pop) begin
         shift_next  = fifo_head;
         parity_next = calc_parity(fifo_head);
      end else if (state == TX_DATA && baud_wrap) begin
         shift_next = shift_reg >> 1;
      end

      bit_idx_next = '0;
      if (state == TX_DATA) bit_idx_next = baud_wrap ? bit_idx + 3'd1 : bit_idx;

      baud_next = baud_cnt + 1'b1;
      if (state == TX_IDLE || baud_wrap || state_next != state) baud_next = '0;

      case (state_next)
         TX_START:  tx_next = 1'b0;
         TX_DATA:   tx_next = shift_next[0];
         TX_PARITY: tx_next = parity_next;
         default:   tx_next = 1'b1;
      endcase

      tx_state       = state;
      tx             = tx_reg;
      bus.tx_done    = (state == TX_STOP) && baud_wrap;
      bus.fifo_full  = fifo_full;
      bus.fifo_empty = fifo_empty;
      bus.overflow   = overflow_reg;
   end

   // Datapath registers; the line register keeps the pin glitch-free and idles high.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         baud_cnt     <= '0;
         bit_idx      <= '0;
         shift_reg    <= '0;
         parity_bit   <= 1'b0;
         tx_reg       <= 1'b1;
         overflow_reg <= 1'b0;
      end else begin
         baud_cnt     <= baud_next;
         bit_idx      <= bit_idx_next;
         shift_reg    <= shift_next;
         parity_bit   <= parity_next;
         tx_reg       <= tx_next;
         overflow_reg <= bus.tx_send && fifo_full && !fifo_pop;
      end
   end

endmodule
